// File: rtl/md_unit_scheduler.sv
// Multiply/divide unit scheduler: computes HI/LO results, models the fixed unit
// latency and raises the D-stage stall while the shared HI/LO resource is occupied.
module md_unit_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        E_start,
  input  logic [1:0]  E_MDOp,
  input  logic [31:0] E_rsValue,
  input  logic [31:0] E_rtValue,
  input  logic        E_mthi,
  input  logic        E_mtlo,
  input  logic        D_MDuse,
  output logic        busy,
  output logic        D_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_hi, r_lo;
  logic [31:0]      r_hi_pend, r_lo_pend;
  logic             r_dz;

  logic        w_signed, w_a_neg, w_b_neg, w_dz;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_q, w_r;
  logic [31:0] w_hi_res, w_lo_res;

  // Result datapath; signed divide goes through magnitudes so INT_MIN/-1 stays defined
  always_comb begin
    w_signed = ~E_MDOp[0];
    w_a_ext  = w_signed ? {{32{E_rsValue[31]}}, E_rsValue} : {32'd0, E_rsValue};
    w_b_ext  = w_signed ? {{32{E_rtValue[31]}}, E_rtValue} : {32'd0, E_rtValue};
    w_prod   = w_a_ext * w_b_ext;

    w_a_neg  = w_signed & E_rsValue[31];
    w_b_neg  = w_signed & E_rtValue[31];
    w_a_mag  = w_a_neg ? (~E_rsValue + 32'd1) : E_rsValue;
    w_b_mag  = w_b_neg ? (~E_rtValue + 32'd1) : E_rtValue;
    w_dz     = E_MDOp[1] & (E_rtValue == 32'd0);
    w_b_safe = (E_rtValue == 32'd0) ? 32'd1 : w_b_mag;
    w_q_mag  = w_a_mag / w_b_safe;
    w_r_mag  = w_a_mag % w_b_safe;
    w_q      = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    w_r      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    w_hi_res = E_MDOp[1] ? w_r : w_prod[63:32];
    w_lo_res = E_MDOp[1] ? w_q : w_prod[31:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_hi_pend <= '0;
      r_lo_pend <= '0;
      r_dz      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (E_start) begin
            r_hi_pend <= w_hi_res;
            r_lo_pend <= w_lo_res;
            r_dz      <= w_dz;
            r_cnt     <= E_MDOp[1] ? DIV_N : MULT_N;
            r_busy    <= 1'b1;
            r_state   <= BUSY;
          end else begin
            if (E_mthi) r_hi <= E_rsValue;
            if (E_mtlo) r_lo <= E_rsValue;
          end
        end
        BUSY: begin
          // Last busy cycle: commit unless the divisor was zero
          if (r_cnt <= CNT_W'(1)) begin
            if (!r_dz) begin
              r_hi <= r_hi_pend;
              r_lo <= r_lo_pend;
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign HI      = r_hi;
  assign LO      = r_lo;
  assign D_stall = D_MDuse & (E_start | r_busy);

endmodule

// File: tb/tb_md_unit_scheduler.sv
// Directed bench for md_unit_scheduler: expected HI/LO pairs are queued at issue
// and compared when busy falls; busy/stall timing is checked every cycle.
module tb_md_unit_scheduler;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        E_start;
  logic [1:0]  E_MDOp;
  logic [31:0] E_rsValue, E_rtValue;
  logic        E_mthi, E_mtlo, D_MDuse;
  logic        busy, D_stall;
  logic [31:0] HI, LO;

  int   n_cmp  = 0;
  int   n_fail = 0;
  res_t sb[$];
  logic [31:0] m_hi, m_lo;

  md_unit_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .E_start(E_start), .E_MDOp(E_MDOp),
    .E_rsValue(E_rsValue), .E_rtValue(E_rtValue), .E_mthi(E_mthi), .E_mtlo(E_mtlo),
    .D_MDuse(D_MDuse), .busy(busy), .D_stall(D_stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the op is sampled at the next posedge
  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic mthi, input logic mtlo);
    E_start = 1'b1; E_MDOp = op; E_rsValue = rs; E_rtValue = rt;
    E_mthi = mthi; E_mtlo = mtlo;
    #1 chk("stall_in_start_cycle", 32'(D_stall), 32'(D_MDuse));
    @(negedge clk);
    E_start = 1'b0; E_mthi = 1'b0; E_mtlo = 1'b0;
  endtask

  // Checks n busy cycles, then the commit against the scoreboard head
  task automatic run_busy(input int n, input int inject_at);
    res_t exp;
    for (int i = 0; i < n; i++) begin
      chk("busy_high", 32'(busy), 32'd1);
      chk("stall_while_busy", 32'(D_stall), 32'(D_MDuse));
      chk("hi_hold_while_busy", HI, m_hi);
      chk("lo_hold_while_busy", LO, m_lo);
      if (i == inject_at) begin
        $display("note: protocol violation injected (E_start/E_mthi while busy)");
        E_start = 1'b1; E_MDOp = 2'b11; E_rsValue = 32'h0000_DEAD; E_rtValue = 32'd3;
        E_mthi = 1'b1;
      end
      @(negedge clk);
      E_start = 1'b0; E_mthi = 1'b0; E_mtlo = 1'b0;
    end
    chk("busy_low_at_commit", 32'(busy), 32'd0);
    chk("stall_low_at_commit", 32'(D_stall), 32'd0);
    chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      m_hi = exp.hi;
      m_lo = exp.lo;
      chk("hi_commit", HI, exp.hi);
      chk("lo_commit", LO, exp.lo);
    end
  endtask

  task automatic move(input logic hi_en, input logic lo_en, input logic [31:0] val);
    E_mthi = hi_en; E_mtlo = lo_en; E_rsValue = val;
    @(negedge clk);
    E_mthi = 1'b0; E_mtlo = 1'b0;
    if (hi_en) m_hi = val;
    if (lo_en) m_lo = val;
    chk("busy_after_move", 32'(busy), 32'd0);
    chk("hi_after_move", HI, m_hi);
    chk("lo_after_move", LO, m_lo);
  endtask

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("busy_stays_low", 32'(busy), 32'd0);
      chk("hi_stays", HI, m_hi);
      chk("lo_stays", LO, m_lo);
    end
  endtask

  initial begin
    reset_n = 1'b0; E_start = 1'b0; E_MDOp = 2'b00; E_rsValue = '0; E_rtValue = '0;
    E_mthi = 1'b0; E_mtlo = 1'b0; D_MDuse = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_stall", 32'(D_stall), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // MTHI/MTLO then divide by zero leaves HI/LO untouched
    move(1'b1, 1'b0, 32'h0000_1234);
    move(1'b0, 1'b1, 32'h0000_5678);
    sb.push_back('{hi: 32'h0000_1234, lo: 32'h0000_5678});
    issue(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
    run_busy(10, -1);

    // MULT 3 * -2
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA});
    issue(2'b00, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_busy(5, -1);

    // MULTU with D_MDuse held: stall in start cycle and all busy cycles
    D_MDuse = 1'b1;
    sb.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001});
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_busy(5, -1);
    D_MDuse = 1'b0;

    // Back-to-back divides: DIVU 7/2, DIV -7/2, DIV 7/-2
    sb.push_back('{hi: 32'd1, lo: 32'd3});
    issue(2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
    run_busy(10, -1);
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_busy(10, -1);
    sb.push_back('{hi: 32'd1, lo: 32'hFFFF_FFFD});
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_busy(10, -1);

    // Both moves at once, then E_start beats simultaneous moves
    move(1'b1, 1'b1, 32'hA5A5_0F0F);
    sb.push_back('{hi: 32'd0, lo: 32'd6});
    issue(2'b00, 32'd2, 32'd3, 1'b1, 1'b1);
    run_busy(5, -1);

    // Reset during busy cycle 4 of a DIV aborts it with no late commit
    issue(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("busy_before_abort", 32'(busy), 32'd1);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_hold(12);

    // Start while busy is ignored; original MULT commits on schedule
    sb.push_back('{hi: 32'd0, lo: 32'h0000_0200});
    issue(2'b00, 32'h10, 32'h20, 1'b0, 1'b0);
    run_busy(5, 1);
    idle_hold(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
